// File: rtl/slave_port_pkg.sv
// Shared serial-bus definitions used by both the master and slave ends of the bus.
package slave_port_pkg;

  localparam int SYS_ADDR_WIDTH       = 16;
  localparam int SYS_DATA_WIDTH       = 8;
  localparam int SLAVE_ADDR_WIDTH     = 4;
  localparam int SLAVE_MEM_ADDR_WIDTH = SYS_ADDR_WIDTH - SLAVE_ADDR_WIDTH;

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } bus_mode_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slave_port_serial_shift_in.sv
// Bit-indexed capture register: writes din into word[idx] on each enabled cycle.
module serial_shift_in #(
  parameter int WIDTH     = 8,
  parameter int IDX_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [IDX_WIDTH-1:0] idx,
  input  logic                 din,
  output logic [WIDTH-1:0]     word
);

  logic [WIDTH-1:0] word_r;

  // capture one serial bit at the addressed position
  always_ff @(posedge clk) begin
    if (rst) begin
      word_r <= '0;
    end else if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (idx == IDX_WIDTH'(i)) begin
          word_r[i] <= din;
        end
      end
    end
  end

  assign word = word_r;

endmodule

// File: rtl/slave_port.sv
// Responder end of the serial system bus: collects address/write data bit-serially,
// issues one parallel device request, and streams read data back LSB first.
module slave_port
  import slave_port_pkg::*;
#(
  parameter  int ADDR_WIDTH = SYS_ADDR_WIDTH,
  parameter  int DATA_WIDTH = SYS_DATA_WIDTH,
  localparam int MEM_AW     = ADDR_WIDTH - SLAVE_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mwdata,
  input  logic                  mmode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic [MEM_AW-1:0]     daddr,
  output logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dmode,
  output logic                  dvalid,
  input  logic [DATA_WIDTH-1:0] drdata,
  input  logic                  dready
);

  localparam int CNT_W  = $clog2(max_int(MEM_AW, DATA_WIDTH));
  localparam int DIDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_REQ   = 3'd3,
    ST_RDATA = 3'd4
  } state_e;

  state_e                  state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  bus_mode_e               mode_r, mode_s;
  logic [DATA_WIDTH-1:0]   rdata_r;
  logic [MEM_AW-1:0]       addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic                    addr_en_s;
  logic                    wdata_en_s;
  logic                    rdata_ld_s;

  serial_shift_in #(.WIDTH(MEM_AW), .IDX_WIDTH(CNT_W)) u_addr_in (
    .clk  (clk),
    .rst  (rst),
    .en   (addr_en_s),
    .idx  (cnt_r),
    .din  (mwdata),
    .word (addr_r)
  );

  serial_shift_in #(.WIDTH(DATA_WIDTH), .IDX_WIDTH(CNT_W)) u_wdata_in (
    .clk  (clk),
    .rst  (rst),
    .en   (wdata_en_s),
    .idx  (cnt_r),
    .din  (mwdata),
    .word (wdata_r)
  );

  // state, bit counter, mode and read-data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      mode_r  <= MODE_READ;
      rdata_r <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      mode_r  <= mode_s;
      if (rdata_ld_s) begin
        rdata_r <= drdata;
      end
    end
  end

  // next-state and capture enables; bus inputs are only looked at while collecting bits
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    mode_s     = mode_r;
    addr_en_s  = 1'b0;
    wdata_en_s = 1'b0;
    rdata_ld_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mvalid) begin
          addr_en_s = 1'b1;
          mode_s    = bus_mode_e'(mmode);
          cnt_s     = CNT_W'(1);
          state_s   = ST_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (mvalid) begin
          addr_en_s = 1'b1;
          if (cnt_r == CNT_W'(MEM_AW - 1)) begin
            cnt_s   = '0;
            state_s = (mode_r == MODE_WRITE) ? ST_WDATA : ST_REQ;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_WDATA: begin
        if (mvalid) begin
          wdata_en_s = 1'b1;
          if (cnt_r == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_s   = '0;
            state_s = ST_REQ;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = ST_WDATA;
        end
      end
      ST_REQ: begin
        if (dready) begin
          cnt_s = '0;
          if (mode_r == MODE_WRITE) begin
            state_s = ST_IDLE;
          end else begin
            rdata_ld_s = 1'b1;
            state_s    = ST_RDATA;
          end
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_RDATA: begin
        if (cnt_r == CNT_W'(DATA_WIDTH - 1)) begin
          cnt_s   = '0;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        cnt_s   = '0;
        state_s = ST_IDLE;
      end
    endcase
  end

  assign sready = (state_r == ST_IDLE);
  assign svalid = (state_r == ST_RDATA);
  assign dvalid = (state_r == ST_REQ);
  assign srdata = (state_r == ST_RDATA) ? rdata_r[cnt_r[DIDX_W-1:0]] : 1'b0;
  assign daddr  = addr_r;
  assign dwdata = wdata_r;
  assign dmode  = mode_r;

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port with a transaction-level bus model checked every cycle.
module tb_slave_port;
  import slave_port_pkg::*;

  localparam int AW = SLAVE_MEM_ADDR_WIDTH;
  localparam int DW = SYS_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mwdata = 1'b0;
  logic          mmode = 1'b0;
  logic          mvalid = 1'b0;
  logic          dready = 1'b0;
  logic [DW-1:0] drdata = '0;
  logic          srdata, svalid, sready, dmode, dvalid;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;

  slave_port dut (
    .clk    (clk),
    .rst    (rst),
    .mwdata (mwdata),
    .mmode  (mmode),
    .mvalid (mvalid),
    .srdata (srdata),
    .svalid (svalid),
    .sready (sready),
    .daddr  (daddr),
    .dwdata (dwdata),
    .dmode  (dmode),
    .dvalid (dvalid),
    .drdata (drdata),
    .dready (dready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // device model: accepts after dev_delay wait cycles and returns dev_rdata
  int            dev_delay = 0;
  int            dev_wait = 0;
  logic [DW-1:0] dev_rdata = '0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (dvalid) begin
        if (dev_wait >= dev_delay) begin
          dready = 1'b1;
          drdata = dev_rdata;
        end else begin
          dready = 1'b0;
          drdata = '0;
          dev_wait++;
        end
      end else begin
        dready = 1'b0;
        dev_wait = 0;
      end
    end
  end

  // transaction-level expectation of the bus, plus logs of what the DUT actually did
  bit            model_on = 1'b0;
  bit            m_busy = 1'b0;
  bit            m_req = 1'b0;
  bit            m_mode = 1'b0;
  int            m_nbits = 0;
  int            m_rcnt = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rword = '0;

  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  logic          log_mode[$];
  int            log_dv[$];
  logic [DW-1:0] rd_words[$];
  logic [DW-1:0] rd_acc = '0;
  int            rd_idx = 0;
  int            dv_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("sready", 32'(sready), 32'(!m_busy));
        check("dvalid", 32'(dvalid), 32'(m_req));
        check("svalid", 32'(svalid), 32'(m_rcnt > 0));
        if (m_req) begin
          check("daddr", 32'(daddr), 32'(m_addr));
          check("dmode", 32'(dmode), 32'(m_mode));
          if (m_mode) check("dwdata", 32'(dwdata), 32'(m_wdata));
        end
        if (m_rcnt > 0) check("srdata", 32'(srdata), 32'(m_rword[DW - m_rcnt]));

        if (dvalid) dv_cnt++;
        if (dvalid && dready) begin
          log_addr.push_back(daddr);
          log_data.push_back(dwdata);
          log_mode.push_back(dmode);
          log_dv.push_back(dv_cnt);
          dv_cnt = 0;
        end
        if (svalid) begin
          rd_acc[rd_idx] = srdata;
          rd_idx++;
          if (rd_idx == DW) begin
            rd_words.push_back(rd_acc);
            rd_idx = 0;
          end
        end

        if (rst) begin
          m_busy = 1'b0; m_req = 1'b0; m_rcnt = 0; m_nbits = 0;
          dv_cnt = 0; rd_idx = 0;
        end else if (m_rcnt > 0) begin
          m_rcnt--;
          if (m_rcnt == 0) m_busy = 1'b0;
        end else if (m_req) begin
          if (dready) begin
            m_req = 1'b0;
            if (m_mode) m_busy = 1'b0;
            else begin
              m_rcnt  = DW;
              m_rword = drdata;
            end
          end
        end else if (m_busy) begin
          if (mvalid) begin
            if (m_nbits < AW) m_addr[m_nbits] = mwdata;
            else m_wdata[m_nbits - AW] = mwdata;
            m_nbits++;
            if (m_nbits == (m_mode ? AW + DW : AW)) m_req = 1'b1;
          end
        end else if (mvalid) begin
          m_busy = 1'b1;
          m_mode = mmode;
          m_addr[0] = mwdata;
          m_nbits = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW+DW-1:0] bits, input int n, input logic mode,
                      input int gap1, input int gap2);
    for (int i = 0; i < n; i++) begin
      if (i == gap1 || i == gap2) begin
        mvalid = 1'b0;
        mwdata = 1'b1;
        mmode  = ~mode;
        repeat (3) tick();
      end
      mvalid = 1'b1;
      mwdata = bits[i];
      mmode  = mode;
      tick();
    end
    mvalid = 1'b0;
    mwdata = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!sready && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(sready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sready"}, 32'(sready), 32'd1);
    check({tag, "_svalid"}, 32'(svalid), 32'd0);
    check({tag, "_srdata"}, 32'(srdata), 32'd0);
    check({tag, "_dvalid"}, 32'(dvalid), 32'd0);
    check({tag, "_daddr"},  32'(daddr),  32'd0);
    check({tag, "_dwdata"}, 32'(dwdata), 32'd0);
    check({tag, "_dmode"},  32'(dmode),  32'd0);
  endtask

  task automatic check_last_req(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic md, input int dv);
    int k = log_addr.size() - 1;
    if (k < 0) begin
      check({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_addr"}, 32'(log_addr[k]), 32'(a));
      check({tag, "_mode"}, 32'(log_mode[k]), 32'(md));
      if (md) check({tag, "_data"}, 32'(log_data[k]), 32'(d));
      check({tag, "_dvcycles"}, 32'(log_dv[k]), 32'(dv));
    end
  endtask

  task automatic check_last_read(input string tag, input logic [DW-1:0] w);
    int k = rd_words.size() - 1;
    if (k < 0) check({tag, "_present"}, 32'd0, 32'd1);
    else check(tag, 32'(rd_words[k]), 32'(w));
  endtask

  initial begin
    int n0;
    int r0;
    int n;

    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    model_on = 1'b1;
    tick();

    // write 0xA5 to 0x123, zero-wait device
    dev_delay = 0;
    n0 = log_addr.size();
    send({8'hA5, 12'h123}, 20, 1'b1, -1, -1);
    wait_idle("wr1_idle");
    check("wr1_count", 32'(log_addr.size() - n0), 32'd1);
    check_last_req("wr1", 12'h123, 8'hA5, 1'b1, 1);

    // read 0xFFF, device returns 0x3C immediately
    dev_rdata = 8'h3C;
    send({8'h00, 12'hFFF}, 12, 1'b0, -1, -1);
    wait_idle("rd1_idle");
    check_last_req("rd1", 12'hFFF, 8'h00, 1'b0, 1);
    check_last_read("rd1_word", 8'h3C);

    // read with device waiting 5 cycles
    dev_delay = 5;
    dev_rdata = 8'h81;
    send({8'h00, 12'h5A5}, 12, 1'b0, -1, -1);
    wait_idle("rd2_idle");
    check_last_req("rd2", 12'h5A5, 8'h00, 1'b0, 6);
    check_last_read("rd2_word", 8'h81);

    // write with 3-cycle gaps in address and data
    dev_delay = 2;
    send({8'h01, 12'h800}, 20, 1'b1, 6, 15);
    wait_idle("wr2_idle");
    check_last_req("wr2", 12'h800, 8'h01, 1'b1, 3);

    // reset during write-data bit 4 discards the transfer
    dev_delay = 0;
    n0 = log_addr.size();
    send({8'hFF, 12'hABC}, 16, 1'b1, -1, -1);
    mvalid = 1'b1;
    mwdata = 1'b1;
    rst = 1'b1;
    tick();
    check_reset_outputs("abort");
    rst = 1'b0;
    mvalid = 1'b0;
    tick();
    check("abort_noreq", 32'(log_addr.size() - n0), 32'd0);
    dev_rdata = 8'h5E;
    send({8'h00, 12'h000}, 12, 1'b0, -1, -1);
    wait_idle("rd3_idle");
    check_last_req("rd3", 12'h000, 8'h00, 1'b0, 1);
    check_last_read("rd3_word", 8'h5E);

    // back-to-back read then write, noise on the bus while busy
    n0 = log_addr.size();
    r0 = rd_words.size();
    dev_rdata = 8'hC3;
    send({8'h00, 12'h0F0}, 12, 1'b0, -1, -1);
    n = 0;
    while (!sready && n < 100) begin
      mvalid = 1'b1;
      mwdata = n[0];
      mmode  = 1'b1;
      tick();
      n++;
    end
    check("b2b_ready", 32'(sready), 32'd1);
    send({8'h7E, 12'h321}, 20, 1'b1, -1, -1);
    wait_idle("b2b_idle");
    check("b2b_count", 32'(log_addr.size() - n0), 32'd2);
    check("b2b_rdcount", 32'(rd_words.size() - r0), 32'd1);
    if (log_addr.size() >= 2) begin
      check("b2b_rd_addr", 32'(log_addr[log_addr.size() - 2]), 32'h0F0);
      check("b2b_rd_mode", 32'(log_mode[log_mode.size() - 2]), 32'd0);
    end
    check_last_req("b2b_wr", 12'h321, 8'h7E, 1'b1, 1);
    check_last_read("b2b_rd_word", 8'hC3);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
